// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe
// Registered LEGv8 instruction-decode stage between fetch and register-file/
// execute. Decodes B/BL, CBZ/CBNZ, LDUR/STUR, ADD/SUB/AND/ORR,
// ADDI/SUBI/ANDI/ORRI and MOVK into register addresses, an extended immediate
// and control bits, and flags anything else as illegal. Each decoded bundle
// sits in an output register backed by one skid entry. Both are controlled by
// valid/ready handshakes and a synchronous flush.
// Optional feature macro: DECODE_PERF_CNT_EN (saturating decoded/illegal counters).
module decode_stage_pipe #(
  parameter int DATA_WIDTH = 64,
  parameter int PC_WIDTH   = 64,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [4:0]            out_rs1,
  output logic [4:0]            out_rs2,
  output logic [4:0]            out_rd,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic [1:0]            out_shift,
  output logic [12:0]           out_ctrl,
  output logic                  out_illegal,
  output logic [CNT_W-1:0]      out_decoded_cnt,
  output logic [CNT_W-1:0]      out_illegal_cnt
);

  // Bit positions inside out_ctrl.
  localparam int REG2LOC  = 0;
  localparam int UNCOND   = 1;
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 3;
  localparam int MEMTOREG = 4;
  localparam int MEMWRITE = 5;
  localparam int ALUSRC   = 6;
  localparam int REGWRITE = 7;
  localparam int ALUOP_LO = 8;
  localparam int BRANCHNE = 10;
  localparam int MOVK     = 11;
  localparam int LINK     = 12;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [DATA_WIDTH-1:0] imm;
    logic [1:0]            shift;
    logic [12:0]           ctrl;
    logic                  illegal;
  } bundle_t;

  bundle_t dec;
  bundle_t out_q;
  bundle_t skid_q;
  logic    out_valid_q;
  logic    skid_valid_q;
  logic    in_fire;
  logic    out_fire;
  logic    out_free;
  logic    is_rtype;
  logic    is_itype;

  assign is_rtype = in_instr[31:21] inside {11'h458, 11'h658, 11'h450, 11'h550};
  assign is_itype = in_instr[31:22] inside {10'h244, 10'h344, 10'h248, 10'h2C8};

  // Decode the incoming word into a bundle; classes are mutually exclusive.
  always_comb begin
    // NOTE: every field is defaulted before the class match, so no path leaves
    // a field unassigned (no latch) and no stale value leaks between classes.
    dec    = '0;
    dec.pc = in_pc;
    if (in_instr[30:26] == 5'b00101) begin
      dec.ctrl[UNCOND] = 1'b1;
      dec.imm          = {{(DATA_WIDTH-26){in_instr[25]}}, in_instr[25:0]};
      if (in_instr[31]) begin
        dec.ctrl[LINK]     = 1'b1;
        dec.ctrl[REGWRITE] = 1'b1;
        dec.rd             = 5'd30;
      end
    end else if (in_instr[31:25] == 7'b1011010) begin
      dec.ctrl[REG2LOC]           = 1'b1;
      dec.ctrl[BRANCH]            = 1'b1;
      dec.ctrl[ALUOP_LO +: 2]     = 2'b01;
      dec.ctrl[BRANCHNE]          = in_instr[24];
      dec.rs2                     = in_instr[4:0];
      dec.imm = {{(DATA_WIDTH-19){in_instr[23]}}, in_instr[23:5]};
    end else if (in_instr[31:23] == 9'b111110000 && !in_instr[21] &&
                 in_instr[11:10] == 2'b00) begin
      dec.ctrl[ALUSRC] = 1'b1;
      dec.rs1          = in_instr[9:5];
      dec.imm = {{(DATA_WIDTH-9){in_instr[20]}}, in_instr[20:12]};
      if (in_instr[22]) begin
        dec.ctrl[MEMREAD]  = 1'b1;
        dec.ctrl[MEMTOREG] = 1'b1;
        dec.ctrl[REGWRITE] = 1'b1;
        dec.rd             = in_instr[4:0];
      end else begin
        dec.ctrl[REG2LOC]  = 1'b1;
        dec.ctrl[MEMWRITE] = 1'b1;
        dec.rs2            = in_instr[4:0];
      end
    end else if (is_rtype) begin
      dec.ctrl[REGWRITE]      = 1'b1;
      dec.ctrl[ALUOP_LO +: 2] = 2'b10;
      dec.rs1                 = in_instr[9:5];
      dec.rs2                 = in_instr[20:16];
      dec.rd                  = in_instr[4:0];
    end else if (is_itype) begin
      dec.ctrl[ALUSRC]        = 1'b1;
      dec.ctrl[REGWRITE]      = 1'b1;
      dec.ctrl[ALUOP_LO +: 2] = 2'b10;
      dec.rs1                 = in_instr[9:5];
      dec.rd                  = in_instr[4:0];
      dec.imm                 = DATA_WIDTH'(in_instr[21:10]);
    end else if (in_instr[31:23] == 9'b111100101) begin
      dec.ctrl[MOVK]          = 1'b1;
      dec.ctrl[REGWRITE]      = 1'b1;
      dec.ctrl[ALUSRC]        = 1'b1;
      dec.ctrl[ALUOP_LO +: 2] = 2'b11;
      dec.rs1                 = in_instr[4:0];
      dec.rd                  = in_instr[4:0];
      dec.imm                 = DATA_WIDTH'(in_instr[20:5]);
      dec.shift               = in_instr[22:21];
    end else begin
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign out_free = out_fire || !out_valid_q;

  // Output register with one skid entry; the skid always drains before new
  // input reaches the output, which keeps delivery strictly in order.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data registers are reset as well, because every output must
    // read zero out of reset, not only the valid flags.
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (out_free) begin
      // NOTE: non-blocking updates mean out_q takes the pre-edge skid_q even
      // though skid_valid_q is cleared in the same edge.
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= 1'b0;
      end else if (in_fire) begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (in_fire) begin
      skid_q       <= dec;
      skid_valid_q <= 1'b1;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_q.pc;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_rd      = out_q.rd;
  assign out_imm     = out_q.imm;
  assign out_shift   = out_q.shift;
  assign out_ctrl    = out_q.ctrl;
  assign out_illegal = out_q.illegal;

`ifdef DECODE_PERF_CNT_EN
  logic [CNT_W-1:0] decoded_cnt_q;
  logic [CNT_W-1:0] illegal_cnt_q;

  // Saturating counts of bundles actually taken by the downstream stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decoded_cnt_q <= '0;
      illegal_cnt_q <= '0;
    end else if (out_fire) begin
      if (decoded_cnt_q != '1) decoded_cnt_q <= decoded_cnt_q + 1'b1;
      if (out_q.illegal && illegal_cnt_q != '1) illegal_cnt_q <= illegal_cnt_q + 1'b1;
    end
  end

  assign out_decoded_cnt = decoded_cnt_q;
  assign out_illegal_cnt = illegal_cnt_q;
`else
  assign out_decoded_cnt = '0;
  assign out_illegal_cnt = '0;
`endif

endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe
// Directed and randomized checks of decode_stage_pipe against a mnemonic-level
// decode model and a 2-deep in-order queue model of the pipeline.
module tb_decode_stage_pipe;
  localparam int DW = 64;
  localparam int PW = 64;
  localparam int CW = 32;
`ifdef DECODE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]   in_instr;
  logic [PW-1:0] in_pc, out_pc;
  logic [4:0]    out_rs1, out_rs2, out_rd;
  logic [DW-1:0] out_imm;
  logic [1:0]    out_shift;
  logic [12:0]   out_ctrl;
  logic [CW-1:0] out_decoded_cnt, out_illegal_cnt;

  decode_stage_pipe #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_shift(out_shift), .out_ctrl(out_ctrl),
    .out_illegal(out_illegal), .out_decoded_cnt(out_decoded_cnt),
    .out_illegal_cnt(out_illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          valid;
    logic [PW-1:0] pc;
    logic [4:0]    rs1, rs2, rd;
    logic [DW-1:0] imm;
    logic [1:0]    shift;
    logic [12:0]   ctrl;
    logic          illegal;
  } view_t;

  typedef enum {M_B, M_BL, M_CBZ, M_CBNZ, M_LDUR, M_STUR, M_ADD, M_SUB, M_AND, M_ORR,
                M_ADDI, M_SUBI, M_ANDI, M_ORRI, M_MOVK, M_ILL} mn_t;

  view_t         q[$];          // bundles held by the stage, oldest first
  logic [CW-1:0] dec_cnt, ill_cnt;
  int            checks = 0;
  int            failures = 0;

  function automatic mn_t classify(input logic [31:0] w);
    if (w[30:26] == 5'b00101) return w[31] ? M_BL : M_B;
    if (w[31:25] == 7'b1011010) return w[24] ? M_CBNZ : M_CBZ;
    if (w[31:23] == 9'b111110000 && w[21] == 1'b0 && w[11:10] == 2'b00)
      return w[22] ? M_LDUR : M_STUR;
    case (w[31:21])
      11'h458: return M_ADD;
      11'h658: return M_SUB;
      11'h450: return M_AND;
      11'h550: return M_ORR;
      default: ;
    endcase
    case (w[31:22])
      10'h244: return M_ADDI;
      10'h344: return M_SUBI;
      10'h248: return M_ANDI;
      10'h2C8: return M_ORRI;
      default: ;
    endcase
    if (w[31:23] == 9'b111100101) return M_MOVK;
    return M_ILL;
  endfunction

  // Control word from named signals: Reg2Loc, Uncondbranch, Branch, MemRead,
  // MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp, BranchNE, Movk, Link.
  function automatic logic [12:0] ctl(input bit r2l, ub, br, mr, m2r, mw, src, rw,
                                      input bit [1:0] op, input bit bne, mk, lk);
    return {lk, mk, bne, op, rw, src, mw, m2r, mr, br, ub, r2l};
  endfunction

  function automatic view_t ref_decode(input logic [31:0] w, input logic [PW-1:0] pc);
    view_t v;
    longint s;
    v = '0;
    v.valid = 1'b1;
    v.pc = pc;
    case (classify(w))
      M_B: begin
        s = $signed(w[25:0]); v.imm = s;
        v.ctrl = ctl(0,1,0,0,0,0,0,0,2'b00,0,0,0);
      end
      M_BL: begin
        s = $signed(w[25:0]); v.imm = s; v.rd = 5'd30;
        v.ctrl = ctl(0,1,0,0,0,0,0,1,2'b00,0,0,1);
      end
      M_CBZ, M_CBNZ: begin
        s = $signed(w[23:5]); v.imm = s; v.rs2 = w[4:0];
        v.ctrl = ctl(1,0,1,0,0,0,0,0,2'b01,classify(w) == M_CBNZ,0,0);
      end
      M_LDUR: begin
        s = $signed(w[20:12]); v.imm = s; v.rs1 = w[9:5]; v.rd = w[4:0];
        v.ctrl = ctl(0,0,0,1,1,0,1,1,2'b00,0,0,0);
      end
      M_STUR: begin
        s = $signed(w[20:12]); v.imm = s; v.rs1 = w[9:5]; v.rs2 = w[4:0];
        v.ctrl = ctl(1,0,0,0,0,1,1,0,2'b00,0,0,0);
      end
      M_ADD, M_SUB, M_AND, M_ORR: begin
        v.rs1 = w[9:5]; v.rs2 = w[20:16]; v.rd = w[4:0];
        v.ctrl = ctl(0,0,0,0,0,0,0,1,2'b10,0,0,0);
      end
      M_ADDI, M_SUBI, M_ANDI, M_ORRI: begin
        v.rs1 = w[9:5]; v.rd = w[4:0]; v.imm = w[21:10];
        v.ctrl = ctl(0,0,0,0,0,0,1,1,2'b10,0,0,0);
      end
      M_MOVK: begin
        v.rs1 = w[4:0]; v.rd = w[4:0]; v.imm = w[20:5]; v.shift = w[22:21];
        v.ctrl = ctl(0,0,0,0,0,0,1,1,2'b11,0,1,0);
      end
      default: v.illegal = 1'b1;
    endcase
    return v;
  endfunction

  function automatic view_t exp_view();
    view_t v;
    v = '0;
    if (q.size() > 0) v = q[0];
    return v;
  endfunction

  function automatic view_t obs_view();
    view_t v;
    v = '0;
    if (out_valid) begin
      v.valid = 1'b1; v.pc = out_pc; v.rs1 = out_rs1; v.rs2 = out_rs2; v.rd = out_rd;
      v.imm = out_imm; v.shift = out_shift; v.ctrl = out_ctrl; v.illegal = out_illegal;
    end else if (out_valid !== 1'b0) begin
      v.valid = out_valid;
    end
    return v;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [10:0] rop;
    logic [9:0]  iop;
    r = $urandom();
    case (r[31:30])
      2'd0: begin rop = 11'h458; iop = 10'h244; end
      2'd1: begin rop = 11'h658; iop = 10'h344; end
      2'd2: begin rop = 11'h450; iop = 10'h248; end
      default: begin rop = 11'h550; iop = 10'h2C8; end
    endcase
    case ($urandom_range(0, 7))
      0: return r;
      1: return {r[31], 5'b00101, r[25:0]};
      2: return {7'b1011010, r[24:0]};
      3: return {9'b111110000, r[22], 1'b0, r[20:12], 2'b00, r[9:0]};
      4: return {rop, r[20:0]};
      5: return {iop, r[21:0]};
      6: return {9'b111100101, r[22:0]};
      default: return 32'h0;
    endcase
  endfunction

  // One clock: drive inputs, advance the queue model at the edge, stop at negedge.
  task automatic tick(input logic v, input logic [31:0] w, input logic [PW-1:0] pc,
                      input logic ordy, input logic fl);
    bit fin, fout;
    in_valid = v; in_instr = w; in_pc = pc; out_ready = ordy; flush = fl;
    fout = (q.size() > 0) && ordy;
    fin  = v && (q.size() < 2);
    @(posedge clk);
    if (fout) begin
      if (dec_cnt != '1) dec_cnt++;
      if (q[0].illegal && ill_cnt != '1) ill_cnt++;
    end
    if (fl) q.delete();
    else begin
      if (fout) void'(q.pop_front());
      if (fin) q.push_back(ref_decode(w, pc));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    q.delete(); dec_cnt = '0; ill_cnt = '0;
    #3;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL reset_hs valid_ready=%b want=01", {out_valid, in_ready});
    end
    checks++;
    if ({out_pc, out_rs1, out_rs2, out_rd, out_imm, out_shift, out_ctrl, out_illegal,
         out_decoded_cnt, out_illegal_cnt} !== '0) begin
      failures++; $display("FAIL reset_outputs ctrl=%h imm=%h pc=%h want all zero",
                           out_ctrl, out_imm, out_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] w[5]    = '{32'h8B020023, 32'hF85F8045, 32'hB5FFFF87, 32'h94000010, 32'h0};
    logic [4:0]  e_rs1[5] = '{5'd1, 5'd2, 5'd0, 5'd0, 5'd0};
    logic [4:0]  e_rs2[5] = '{5'd2, 5'd0, 5'd7, 5'd0, 5'd0};
    logic [4:0]  e_rd[5]  = '{5'd3, 5'd5, 5'd0, 5'd30, 5'd0};
    logic [12:0] e_ctl[5] = '{13'h0280, 13'h00D8, 13'h0505, 13'h1082, 13'h0000};
    logic [DW-1:0] e_imm[5] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC,
                                64'd16, 64'd0};
    logic        e_ill[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, w[i], PW'(32'h1000 + 4 * i), 1'b1, 1'b0);
      checks++;
      if ({out_valid, out_pc, out_rs1, out_rs2, out_rd, out_ctrl, out_imm, out_illegal} !==
          {1'b1, PW'(32'h1000 + 4 * i), e_rs1[i], e_rs2[i], e_rd[i], e_ctl[i], e_imm[i], e_ill[i]}) begin
        failures++;
        $display("FAIL directed_%0d got v=%b rs=%0d/%0d/%0d ctrl=%h imm=%h ill=%b want rs=%0d/%0d/%0d ctrl=%h imm=%h ill=%b",
                 i, out_valid, out_rs1, out_rs2, out_rd, out_ctrl, out_imm, out_illegal,
                 e_rs1[i], e_rs2[i], e_rd[i], e_ctl[i], e_imm[i], e_ill[i]);
      end
    end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if ({out_valid, in_ready, out_decoded_cnt, out_illegal_cnt} !==
        {1'b0, 1'b1, PERF ? CW'(5) : CW'(0), PERF ? CW'(1) : CW'(0)}) begin
      failures++; $display("FAIL directed_counts valid=%b ready=%b dec=%0d ill=%0d",
                           out_valid, in_ready, out_decoded_cnt, out_illegal_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[3] = '{32'h8B020023, 32'h91000421, 32'hF2A00041};
    logic [2:0]  v_s[6] = '{1, 1, 1, 1, 1, 0};
    logic [2:0]  idx[6] = '{0, 1, 2, 2, 2, 0};
    logic        rdy[6] = '{0, 0, 0, 1, 1, 1};
    logic        e_in_rdy[6] = '{1, 0, 0, 1, 1, 1};
    logic [PW-1:0] e_pc[6] = '{PW'(32'hA0), PW'(32'hA0), PW'(32'hA0), PW'(32'hA4), PW'(32'hA8), PW'(0)};
    view_t o, e;
    for (int i = 0; i < 6; i++) begin
      tick(v_s[i][0], w[idx[i]], PW'(32'hA0 + 4 * idx[i]), rdy[i], 1'b0);
      o = obs_view(); e = exp_view();
      checks++;
      if (o !== e) begin failures++; $display("FAIL bp_bundle_%0d got=%h want=%h", i, o, e); end
      checks++;
      if ({in_ready, o.pc} !== {e_in_rdy[i], e_pc[i]}) begin
        failures++; $display("FAIL bp_order_%0d ready=%b pc=%h want ready=%b pc=%h",
                             i, in_ready, o.pc, e_in_rdy[i], e_pc[i]);
      end
    end
  endtask

  task automatic test_flush();
    tick(1'b1, 32'h8B020023, PW'(32'hB0), 1'b0, 1'b0);
    tick(1'b1, 32'hCB020023, PW'(32'hB4), 1'b0, 1'b0);
    checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      failures++; $display("FAIL flush_full valid_ready=%b want=10", {out_valid, in_ready});
    end
    tick(1'b1, 32'hAA020023, PW'(32'hB8), 1'b0, 1'b1);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      failures++; $display("FAIL flush_clear valid_ready=%b want=01", {out_valid, in_ready});
    end
    tick(1'b0, '0, '0, 1'b1, 1'b0);
    checks++;
    if ({out_valid, out_decoded_cnt, out_illegal_cnt} !== {1'b0, PERF ? dec_cnt : '0, PERF ? ill_cnt : '0}) begin
      failures++; $display("FAIL flush_drop valid=%b dec=%0d ill=%0d want valid=0 dec=%0d ill=%0d",
                           out_valid, out_decoded_cnt, out_illegal_cnt, dec_cnt, ill_cnt);
    end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 32'h8B020023, PW'(32'hC0), 1'b0, 1'b0);
    tick(1'b1, 32'h0, PW'(32'hC4), 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    q.delete(); dec_cnt = '0; ill_cnt = '0;
    checks++;
    if ({out_valid, in_ready, out_decoded_cnt, out_illegal_cnt} !== {2'b01, CW'(0), CW'(0)}) begin
      failures++; $display("FAIL reset_mid valid=%b ready=%b dec=%0d ill=%0d",
                           out_valid, in_ready, out_decoded_cnt, out_illegal_cnt);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    view_t o, e;
    for (int i = 0; i < 40; i++) begin
      tick(1'b1, gen_instr(), PW'($urandom()), 1'b1, 1'b0);
      o = obs_view(); e = exp_view();
      checks++;
      if (o !== e || in_ready !== 1'b1) begin
        failures++; $display("FAIL b2b_%0d ready=%b got=%h want=%h", i, in_ready, o, e);
      end
    end
  endtask

  task automatic test_random();
    view_t o, e;
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 3) != 0, gen_instr(), {$urandom(), $urandom()},
           $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0);
      o = obs_view(); e = exp_view();
      checks++;
      if (o !== e) begin failures++; $display("FAIL rand_bundle_%0d got=%h want=%h", i, o, e); end
      checks++;
      if (in_ready !== (q.size() < 2)) begin
        failures++; $display("FAIL rand_ready_%0d got=%b want=%b", i, in_ready, q.size() < 2);
      end
      checks++;
      if ({out_decoded_cnt, out_illegal_cnt} !== {PERF ? dec_cnt : '0, PERF ? ill_cnt : '0}) begin
        failures++; $display("FAIL rand_cnt_%0d got=%0d/%0d want=%0d/%0d", i, out_decoded_cnt,
                             out_illegal_cnt, PERF ? dec_cnt : '0, PERF ? ill_cnt : '0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
Registered, parametrised LEGv8 instruction-decode pipeline stage sitting between fetch and the register-file/execute stage. It decodes the LEGv8 subset (B/BL, CBZ/CBNZ, LDUR/STUR, ADD/SUB/AND/ORR, ADDI/SUBI/ANDI/ORRI, MOVK) into register addresses, an extended immediate and control signals. Unlike a purely combinational decoder, it drives defined defaults for every field, flags illegal encodings, and uses valid/ready handshakes with a 2-entry skid buffer and a flush.

Parameters:
DATA_WIDTH, 64, width of out_imm (sign/zero-extension target), >= 32
PC_WIDTH, 64, width of in_pc/out_pc
CNT_W, 32, width of performance counters (optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous: discard all held and incoming instructions
in_valid  in  1  fetch presents in_instr/in_pc
in_ready  out  1  stage accepts this cycle; equals !skid_valid
in_instr  in  32  instruction word
in_pc  in  PC_WIDTH  instruction address, passed through
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts
out_pc  out  PC_WIDTH  pc of decoded instruction
out_rs1 / out_rs2 / out_rd  out  5 each  register addresses
out_imm  out  DATA_WIDTH  extended immediate
out_shift  out  2  MOVK hw field, else 0
out_ctrl  out  13  [0]Reg2Loc [1]Uncondbranch [2]Branch [3]MemRead [4]MemtoReg [5]MemWrite [6]ALUSrc [7]RegWrite [9:8]ALUOp [10]BranchNE [11]Movk [12]Link
out_illegal  out  1  instruction matched no class
out_decoded_cnt  out  CNT_W  accepted-output count (feature)
out_illegal_cnt  out  CNT_W  illegal count (feature)

Behaviour:
- Reset: out_valid=0, skid empty, in_ready=1, all other outputs 0.
- Decode is combinational on in_instr; every field defaults to 0 before class match (no held values). Captured in same cycle as in_valid&&in_ready.
- B/BL: [30:26]=00101. Uncondbranch=1, imm=sext([25:0]). BL ([31]=1): Link=1, RegWrite=1, rd=30.
- CBZ/CBNZ: [31:25]=1011010. Reg2Loc=1, Branch=1, ALUOp=01, rs2=[4:0], imm=sext([23:5]), BranchNE=[24].
- LDUR/STUR: [31:23]=111110000, [21]=0, [11:10]=00. ALUSrc=1, ALUOp=00, rs1=[9:5], imm=sext([20:12]). [22]=1 load: MemRead=1, MemtoReg=1, RegWrite=1, rd=[4:0]. [22]=0 store: Reg2Loc=1, MemWrite=1, rs2=[4:0].
- R-type: [31:21] in {0x458 ADD, 0x658 SUB, 0x450 AND, 0x550 ORR}. RegWrite=1, ALUOp=10, rs1=[9:5], rs2=[20:16], rd=[4:0].
- I-type: [31:22] in {0x244 ADDI, 0x344 SUBI, 0x248 ANDI, 0x2C8 ORRI}. ALUSrc=1, RegWrite=1, ALUOp=10, rs1=[9:5], rd=[4:0], imm=zext([21:10]).
- MOVK: [31:23]=111100101. Movk=1, RegWrite=1, ALUSrc=1, ALUOp=11, rs1=rd=[4:0], imm=zext([20:5]), shift=[22:21].
- No match: out_illegal=1, ctrl/regs/imm 0; still flows through pipeline.
- Latency 1 cycle; throughput 1/cycle when out_ready=1.
- Pipeline: output register + skid register. Accept while out stalled (out_valid&&!out_ready) -> skid. On output fire, output reloads from skid if full, else from input, else clears valid. Strict in-order.
- Simultaneous fire-in and fire-out with skid empty: output register takes new bundle directly.
- flush: next edge out_valid=0, skid empty; input presented that cycle dropped; counters unaffected by dropped entries. flush has priority over all.
- Reset mid-operation: all state cleared immediately.

Optional Feature:
DECODE_PERF_CNT_EN: defined -> out_decoded_cnt increments on each out_valid&&out_ready, out_illegal_cnt additionally when out_illegal; both saturate at all-ones, reset to 0. Undefined -> counters absent, ports tied to 0.

Test Plan:
- ADD X3,X1,X2 0x8B020023, out_ready=1 -> next cycle out_valid=1, rs1=1, rs2=2, rd=3, RegWrite=1, ALUOp=10, imm=0.
- LDUR X5,[X2,#-8] 0xF85F8045 -> rs1=2, rd=5, MemRead=MemtoReg=RegWrite=ALUSrc=1, imm=0xFFFF_FFFF_FFFF_FFF8.
- CBNZ X7,#-4 0xB5FFFF87 -> rs2=7, Branch=1, BranchNE=1, Reg2Loc=1, ALUOp=01, imm=-4; BL 0x94000010 -> Link=1, rd=30, imm=16.
- out_ready=0, stream A,B,C -> A,B accepted, in_ready=0 holding C; out_ready=1 -> outputs A,B,C in order, no loss/duplication.
- Output and skid full, flush=1 one cycle -> out_valid=0, in_ready=1 next cycle; concurrent input dropped.
- 0x00000000 -> out_illegal=1, out_ctrl=0; with DECODE_PERF_CNT_EN, after the four legal plus this one fire, decoded_cnt=5, illegal_cnt=1.
